// File: rtl/mips_chk_pkg.sv
// Shared types for the MIPS register-trace checker.
// Holds the observed/expected triple layout, mask bit positions and FSM states.
package mips_chk_pkg;

  typedef struct packed {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] rd;
  } reg_triple_t;

  localparam int MASK_RS = 0;
  localparam int MASK_RT = 1;
  localparam int MASK_RD = 2;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } chk_state_t;

endpackage

// File: rtl/chk_fifo.sv
// Synchronous FIFO of observed register triples.
// Push on a full FIFO is accepted only when a pop frees a slot the same cycle.
module chk_fifo
  import mips_chk_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  reg_triple_t din,
  output reg_triple_t dout,
  output logic        full,
  output logic        empty,
  output logic [LW-1:0] level
);

  reg_triple_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mips_reg_checker.sv
// Compares buffered CPU register triples against golden-model triples.
// Reports per-field mismatches, saturating counts and a sticky first error.
module mips_reg_checker
  import mips_chk_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  parameter bit STOP_ON_ERR = 1'b0,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             obs_valid,
  input  logic [31:0]      obs_rs,
  input  logic [31:0]      obs_rt,
  input  logic [31:0]      obs_rd,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [31:0]      exp_rs,
  input  logic [31:0]      exp_rt,
  input  logic [31:0]      exp_rd,
  output logic             err_valid,
  output logic [2:0]       err_mask,
  output logic [CNT_W-1:0] err_index,
  output logic             first_err_seen,
  output logic [CNT_W-1:0] first_err_index,
  output logic [2:0]       first_err_mask,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             overflow,
  output logic [LW-1:0]    fifo_level
);

  chk_state_t state;
  chk_state_t state_nx;
  reg_triple_t obs;
  reg_triple_t head;
  logic full;
  logic empty;
  logic pop;
  logic [2:0] cmp_mask;

  logic             res_valid;
  logic [2:0]       res_mask;
  logic [CNT_W-1:0] res_index;
  logic [CNT_W-1:0] idx;
  logic             res_bad;

  assign obs     = '{rs: obs_rs, rt: obs_rt, rd: obs_rd};
  assign pop     = exp_valid && exp_ready;
  assign res_bad = res_valid && (res_mask != 3'b000);

  chk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (obs_valid),
    .pop   (pop),
    .din   (obs),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    cmp_mask = '0;
    cmp_mask[MASK_RS] = (head.rs != exp_rs);
    cmp_mask[MASK_RT] = (head.rt != exp_rt);
    cmp_mask[MASK_RD] = (head.rd != exp_rd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) state <= RUN;
    else                 state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:  if (STOP_ON_ERR && res_bad) state_nx = HALT;
      HALT: state_nx = HALT;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    exp_ready = !empty && (state == RUN);
  end

  // Compare result is staged one cycle before it reaches the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      res_valid <= 1'b0;
      res_mask  <= '0;
      res_index <= '0;
      idx       <= '0;
    end else begin
      res_valid <= pop;
      if (pop) begin
        res_mask  <= cmp_mask;
        res_index <= idx;
        idx       <= idx + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      err_valid       <= 1'b0;
      err_mask        <= '0;
      err_index       <= '0;
      first_err_seen  <= 1'b0;
      first_err_index <= '0;
      first_err_mask  <= '0;
      match_cnt       <= '0;
      mismatch_cnt    <= '0;
      overflow        <= 1'b0;
    end else begin
      err_valid <= res_bad;
      if (res_bad) begin
        err_mask  <= res_mask;
        err_index <= res_index;
        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (!first_err_seen) begin
          first_err_seen  <= 1'b1;
          first_err_index <= res_index;
          first_err_mask  <= res_mask;
        end
      end
      if (res_valid && !res_bad && match_cnt != '1)
        match_cnt <= match_cnt + CNT_W'(1);
      if (obs_valid && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_reg_checker.sv
// Directed bench for mips_reg_checker.
// dut_a: DEPTH=4, CNT_W=32, no halt; dut_b: DEPTH=4, CNT_W=4, halt on error.
module tb_mips_reg_checker;

  logic        clk = 1'b0;
  logic        rst_n, clear;
  logic        obs_valid, exp_valid;
  logic [31:0] obs_rs, obs_rt, obs_rd;
  logic [31:0] exp_rs, exp_rt, exp_rd;

  logic        exp_ready_a, err_valid_a, first_err_seen_a, overflow_a;
  logic [2:0]  err_mask_a, first_err_mask_a;
  logic [31:0] err_index_a, first_err_index_a, match_cnt_a, mismatch_cnt_a;
  logic [2:0]  fifo_level_a;

  logic        exp_ready_b, err_valid_b, first_err_seen_b, overflow_b;
  logic [2:0]  err_mask_b, first_err_mask_b;
  logic [3:0]  err_index_b, first_err_index_b, match_cnt_b, mismatch_cnt_b;
  logic [2:0]  fifo_level_b;

  int tests = 0;
  int fails = 0;
  int pulses_a = 0;

  always #5 clk = ~clk;

  mips_reg_checker #(.DEPTH(4), .CNT_W(32), .STOP_ON_ERR(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .obs_valid(obs_valid), .obs_rs(obs_rs), .obs_rt(obs_rt), .obs_rd(obs_rd),
    .exp_valid(exp_valid), .exp_ready(exp_ready_a),
    .exp_rs(exp_rs), .exp_rt(exp_rt), .exp_rd(exp_rd),
    .err_valid(err_valid_a), .err_mask(err_mask_a), .err_index(err_index_a),
    .first_err_seen(first_err_seen_a), .first_err_index(first_err_index_a),
    .first_err_mask(first_err_mask_a),
    .match_cnt(match_cnt_a), .mismatch_cnt(mismatch_cnt_a),
    .overflow(overflow_a), .fifo_level(fifo_level_a)
  );

  mips_reg_checker #(.DEPTH(4), .CNT_W(4), .STOP_ON_ERR(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .obs_valid(obs_valid), .obs_rs(obs_rs), .obs_rt(obs_rt), .obs_rd(obs_rd),
    .exp_valid(exp_valid), .exp_ready(exp_ready_b),
    .exp_rs(exp_rs), .exp_rt(exp_rt), .exp_rd(exp_rd),
    .err_valid(err_valid_b), .err_mask(err_mask_b), .err_index(err_index_b),
    .first_err_seen(first_err_seen_b), .first_err_index(first_err_index_b),
    .first_err_mask(first_err_mask_b),
    .match_cnt(match_cnt_b), .mismatch_cnt(mismatch_cnt_b),
    .overflow(overflow_b), .fifo_level(fifo_level_b)
  );

  always @(negedge clk) if (err_valid_a === 1'b1) pulses_a++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    obs_rs = a; obs_rt = b; obs_rd = c;
    obs_valid = 1'b1;
    step();
    obs_valid = 1'b0;
  endtask

  task automatic expect_t(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    exp_rs = a; exp_rt = b; exp_rd = c;
    exp_valid = 1'b1;
    step();
    exp_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    obs_valid = 1'b0; exp_valid = 1'b0;
    obs_rs = '0; obs_rt = '0; obs_rd = '0;
    exp_rs = '0; exp_rt = '0; exp_rd = '0;
    step(); step();
    rst_n = 1'b1;

    // reset with a mismatching result in flight
    push(1, 1, 1); push(2, 2, 2); push(3, 3, 3);
    chk("pre_rst_level", fifo_level_a, 3);
    exp_rs = 9; exp_rt = 9; exp_rd = 9; exp_valid = 1'b1;
    step();
    exp_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_level_a", fifo_level_a, 0);
    chk("rst_level_b", fifo_level_b, 0);
    chk("rst_match", match_cnt_a, 0);
    chk("rst_mismatch", mismatch_cnt_a, 0);
    chk("rst_overflow", overflow_a, 0);
    chk("rst_first_seen", first_err_seen_a, 0);
    chk("rst_err_valid", err_valid_a, 0);
    step();
    chk("rst_err_valid_next", err_valid_a, 0);
    chk("rst_mismatch_next", mismatch_cnt_a, 0);

    // matching stream
    pulses_a = 0;
    push(1, 2, 3); push(4, 5, 6);
    expect_t(1, 2, 3); expect_t(4, 5, 6);
    step(); step();
    chk("match_cnt_a", match_cnt_a, 2);
    chk("match_cnt_b", match_cnt_b, 2);
    chk("match_mismatch", mismatch_cnt_a, 0);
    chk("match_no_err", pulses_a, 0);
    chk("match_level", fifo_level_a, 0);

    // mismatches after clear
    do_clear();
    chk("clr_match", match_cnt_a, 0);
    push(32'h10, 32'h20, 32'h30);
    expect_t(32'h10, 32'h21, 32'h31);
    chk("mm_no_early_err", err_valid_a, 0);
    step();
    chk("mm_err_valid", err_valid_a, 1);
    chk("mm_err_mask", err_mask_a, 3'b110);
    chk("mm_err_index", err_index_a, 0);
    chk("mm_first_seen", first_err_seen_a, 1);
    chk("mm_first_index", first_err_index_a, 0);
    chk("mm_first_mask", first_err_mask_a, 3'b110);
    step();
    chk("mm_pulse_end", err_valid_a, 0);
    push(1, 1, 1);
    expect_t(2, 1, 1);
    step();
    chk("mm2_err_valid", err_valid_a, 1);
    chk("mm2_err_mask", err_mask_a, 3'b001);
    chk("mm2_err_index", err_index_a, 1);
    chk("mm2_first_index", first_err_index_a, 0);
    chk("mm2_first_mask", first_err_mask_a, 3'b110);
    chk("mm2_mismatch_a", mismatch_cnt_a, 2);
    chk("mm2_halt_ready_b", exp_ready_b, 0);
    chk("mm2_halt_level_b", fifo_level_b, 1);
    chk("mm2_mismatch_b", mismatch_cnt_b, 1);

    // fill, push+pop while full, then drop
    do_clear();
    for (int i = 0; i < 4; i++) push(i, i, i);
    chk("full_level", fifo_level_a, 4);
    chk("full_no_ovf", overflow_a, 0);
    obs_rs = 9; obs_rt = 9; obs_rd = 9; obs_valid = 1'b1;
    exp_rs = 0; exp_rt = 0; exp_rd = 0; exp_valid = 1'b1;
    step();
    obs_valid = 1'b0; exp_valid = 1'b0;
    chk("pp_level", fifo_level_a, 4);
    chk("pp_no_ovf", overflow_a, 0);
    push(5, 5, 5);
    chk("drop_level", fifo_level_a, 4);
    chk("drop_ovf", overflow_a, 1);
    step();
    chk("pp_match", match_cnt_a, 1);
    chk("pp_mismatch", mismatch_cnt_a, 0);

    // halt on mismatch at index 2 with exp_valid held
    do_clear();
    for (int i = 1; i <= 4; i++) push(i, i, i);
    obs_rs = 5; obs_rt = 5; obs_rd = 5; obs_valid = 1'b1;
    exp_rs = 1; exp_rt = 1; exp_rd = 1; exp_valid = 1'b1;
    step();
    obs_valid = 1'b0;
    exp_rs = 2; exp_rt = 2; exp_rd = 2;
    step();
    exp_rs = 0; exp_rt = 3; exp_rd = 3;
    step();
    exp_rs = 4; exp_rt = 4; exp_rd = 4;
    step();
    chk("halt_err_valid", err_valid_b, 1);
    chk("halt_err_index", err_index_b, 2);
    chk("halt_err_mask", err_mask_b, 3'b001);
    chk("halt_ready", exp_ready_b, 0);
    exp_rs = 5; exp_rt = 5; exp_rd = 5;
    step(); step();
    exp_valid = 1'b0;
    chk("halt_match", match_cnt_b, 3);
    chk("halt_mismatch", mismatch_cnt_b, 1);
    chk("halt_level", fifo_level_b, 1);
    chk("halt_ready_hold", exp_ready_b, 0);
    chk("halt_first_index", first_err_index_b, 2);
    chk("run_a_match", match_cnt_a, 4);
    chk("run_a_mismatch", mismatch_cnt_a, 1);
    do_clear();
    chk("hclr_match", match_cnt_b, 0);
    chk("hclr_mismatch", mismatch_cnt_b, 0);
    chk("hclr_level", fifo_level_b, 0);
    chk("hclr_first_seen", first_err_seen_b, 0);
    push(6, 6, 6);
    chk("hclr_run_ready", exp_ready_b, 1);

    // saturation of the 4-bit counter
    do_clear();
    for (int i = 0; i < 17; i++) begin
      push(7, 7, 7);
      expect_t(7, 7, 7);
    end
    step(); step();
    chk("sat_match_b", match_cnt_b, 15);
    chk("sat_mismatch_b", mismatch_cnt_b, 0);
    chk("sat_match_a", match_cnt_a, 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
